// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types, constants and the round-robin pick function for the
// RAMHelper port arbiter.
//   state_t  : access FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   WORD_W   : RAMHelper word / index width
//   MAX_REQ  : widest requester vector supported (N_REQ is 1..4)
//   PTR_W    : width of a requester id / round-robin pointer
//   WAIT_W   : width of the ACCESS stall counter (WAIT_CYC is 0..15)
//   rr_pick  : one-hot grant of the first valid at or above ptr, wrapping
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int WORD_W  = 64;
  localparam int MAX_REQ = 4;
  localparam int PTR_W   = 2;
  localparam int WAIT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Isolates the least significant set bit (two's complement trick).
  function automatic logic [MAX_REQ-1:0] lowest_one(input logic [MAX_REQ-1:0] v);
    return v & ((~v) + MAX_REQ'(1));
  endfunction

  // Requesters at or above ptr win first; if none of them is valid the search
  // wraps around, which is the same as taking the lowest valid overall.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] below;
    logic [MAX_REQ-1:0] upper;
    below = (MAX_REQ'(1) << ptr) - MAX_REQ'(1);
    upper = valid & ~below;
    if (upper != '0) begin
      return lowest_one(upper);
    end
    return lowest_one(valid);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter over N requesters.
//   valid_i    in   N      request pending per requester
//   ptr_i      in   PTR_W  highest-priority requester this round
//   grant_o    out  N      one-hot grant (or zero when nothing is valid)
//   grantId_o  out  PTR_W  binary id of the granted requester
//   anyGrant_o out  1      some requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] grantId_o,
  output logic             anyGrant_o
);

  logic [MAX_REQ-1:0] validExt;
  logic [MAX_REQ-1:0] grantExt;

  // Widen to the package vector size, pick, and encode the winner's id.
  // Bits above N are never valid, so they can never be granted.
  always_comb begin
    validExt = '0;
    validExt[N-1:0] = valid_i;
    grantExt = rr_pick(validExt, ptr_i);
    grant_o = grantExt[N-1:0];
    grantId_o = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (grantExt[i]) begin
        grantId_o = PTR_W'(i);
      end
    end
    anyGrant_o = |grantExt;
  end

endmodule

// File: rtl/ram_helper_arbiter.sv
// ---------------------------------------------------------------------------
// ram_helper_arbiter
// Shares one RAMHelper memory port between N_REQ requesters (e.g. ifetch=0,
// LSU=1) with round-robin arbitration and a single outstanding access.
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot)
//   req_wen/idx/wdata/wmask  per-requester request payload, 64-bit slices
//   resp_valid/resp_ready per-requester response handshake
//   resp_rdata            shared read data, qualified by resp_valid
//   ram_*                 RAMHelper port; rdata is combinational from rIdx/en,
//                         a write commits at the posedge after ram_wen
// Parameters: N_REQ (1..4) requesters, WAIT_CYC (0..15) extra ACCESS cycles.
// ---------------------------------------------------------------------------
module ram_helper_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int WAIT_CYC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_wen,
  input  logic [N_REQ*WORD_W-1:0] req_idx,
  input  logic [N_REQ*WORD_W-1:0] req_wdata,
  input  logic [N_REQ*WORD_W-1:0] req_wmask,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [WORD_W-1:0]       resp_rdata,
  output logic                    ram_en,
  output logic [WORD_W-1:0]       ram_rIdx,
  input  logic [WORD_W-1:0]       ram_rdata,
  output logic [WORD_W-1:0]       ram_wIdx,
  output logic [WORD_W-1:0]       ram_wdata,
  output logic [WORD_W-1:0]       ram_wmask,
  output logic                    ram_wen
);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [WORD_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WORD_W-1:0]  wmask_q, wmask_d;
  logic               wen_q, wen_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;

  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   grantId;
  logic               anyGrant;

  logic               selWen;
  logic [WORD_W-1:0]  selIdx;
  logic [WORD_W-1:0]  selWdata;
  logic [WORD_W-1:0]  selWmask;
  logic [MAX_REQ-1:0] respReadyExt;
  logic               lastAccessCycle;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .valid_i    (req_valid),
    .ptr_i      (rrPtr_q),
    .grant_o    (grant),
    .grantId_o  (grantId),
    .anyGrant_o (anyGrant)
  );

  // Payload mux driven by the one-hot grant; only consumed on the accept cycle.
  // Also widens resp_ready so the owner id can index it without width games.
  always_comb begin
    selWen   = 1'b0;
    selIdx   = '0;
    selWdata = '0;
    selWmask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        selWen   = req_wen[i];
        selIdx   = req_idx[i*WORD_W +: WORD_W];
        selWdata = req_wdata[i*WORD_W +: WORD_W];
        selWmask = req_wmask[i*WORD_W +: WORD_W];
      end
    end
    respReadyExt = '0;
    respReadyExt[N_REQ-1:0] = resp_ready;
  end

  assign lastAccessCycle = (state_q == ACCESS) && (waitCnt_q == '0);

  // Next-state logic. IDLE accepts the arbiter's winner and latches its
  // payload; ACCESS counts down the modelled latency and samples the RAM on
  // its last cycle, which is the same edge the write commits on, so the
  // captured word is always the pre-write value; RESP waits for the owner.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    waitCnt_d = waitCnt_q;
    owner_d   = owner_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    wen_d     = wen_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (anyGrant) begin
          owner_d   = grantId;
          idx_d     = selIdx;
          wdata_d   = selWdata;
          wmask_d   = selWmask;
          wen_d     = selWen;
          rrPtr_d   = (grantId == PTR_W'(N_REQ - 1)) ? '0 : grantId + PTR_W'(1);
          waitCnt_d = WAIT_W'(WAIT_CYC);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (waitCnt_q == '0) begin
          rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - WAIT_W'(1);
        end
      end
      RESP: begin
        if (respReadyExt[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state in one register bank. Reset clears the payload latches as well
  // so every index/data/mask output reads zero while reset is held, and a
  // write caught mid-ACCESS simply never reaches its commit cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      waitCnt_q <= '0;
      owner_q   <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      wen_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      waitCnt_q <= waitCnt_d;
      owner_q   <= owner_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      wen_q     <= wen_d;
      rdata_q   <= rdata_d;
    end
  end

  // Grant is only offered from IDLE; reset masks it because the arbiter
  // itself is combinational and would otherwise follow req_valid.
  assign req_ready = ((state_q == IDLE) && !reset) ? grant : '0;

  // The owner sees its response until it takes it.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid[i] = (state_q == RESP) && (owner_q == PTR_W'(i));
    end
  end

  // RAM port decoded from registered state; the write strobe exists only on
  // the final ACCESS cycle, so each write fires exactly once.
  assign ram_en     = (state_q == ACCESS);
  assign ram_wen    = lastAccessCycle && wen_q;
  assign ram_rIdx   = idx_q;
  assign ram_wIdx   = idx_q;
  assign ram_wdata  = wdata_q;
  assign ram_wmask  = wmask_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_ram_helper_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_helper_arbiter
// Drives two requesters into the arbiter (WAIT_CYC=3) with a small behavioural
// RAMHelper stub. A reference model predicts grants, response timing and read
// data from the arbitration rules; expected responses go into a scoreboard
// queue that a separate negedge monitor checks against the DUT.
// ---------------------------------------------------------------------------
module tb_ram_helper_arbiter;

  localparam int N         = 2;
  localparam int WAIT      = 3;
  localparam int MEM_WORDS = 32;

  typedef struct {
    logic        wen;
    logic [63:0] idx;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } cmd_t;

  typedef struct {
    int          owner;
    logic [63:0] idx;
    logic [63:0] rdata;
    logic        isWrite;
    int          due;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wen;
  logic [N*64-1:0] req_idx;
  logic [N*64-1:0] req_wdata;
  logic [N*64-1:0] req_wmask;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [63:0]     resp_rdata;
  logic            ram_en;
  logic [63:0]     ram_rIdx;
  logic [63:0]     ram_rdata;
  logic [63:0]     ram_wIdx;
  logic [63:0]     ram_wdata;
  logic [63:0]     ram_wmask;
  logic            ram_wen;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [63:0] stubMem [MEM_WORDS];
  logic [63:0] refMem  [MEM_WORDS];

  exp_t         expQ[$];
  cmd_t         cmdQ0[$];
  cmd_t         cmdQ1[$];
  cmd_t         cur [N];
  logic [N-1:0] prevReady;
  int           rrPtr;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  ram_helper_arbiter #(
    .N_REQ    (N),
    .WAIT_CYC (WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_idx    (req_idx),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .ram_en     (ram_en),
    .ram_rIdx   (ram_rIdx),
    .ram_rdata  (ram_rdata),
    .ram_wIdx   (ram_wIdx),
    .ram_wdata  (ram_wdata),
    .ram_wmask  (ram_wmask),
    .ram_wen    (ram_wen)
  );

  // RAMHelper stand-in: combinational read, masked write at the posedge.
  assign ram_rdata = ram_en ? stubMem[ram_rIdx[4:0]] : 64'd0;

  always @(posedge clk) begin
    if (ram_wen) begin
      stubMem[ram_wIdx[4:0]] <= (stubMem[ram_wIdx[4:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round robin in plain terms: walk from the pointer, first valid wins.
  function automatic int modelPick(input logic [N-1:0] v, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic cmd_t randomCmd();
    cmd_t c;
    c.wen   = 1'($urandom_range(1));
    c.idx   = 64'($urandom_range(MEM_WORDS - 1));
    c.wdata = {$urandom, $urandom};
    c.wmask = ($urandom_range(1) == 0) ? '1 : {$urandom, $urandom};
    return c;
  endfunction

  task automatic presentCmd(input int i, input cmd_t c);
    cur[i] = c;
    req_valid[i] = 1'b1;
    req_wen[i] = c.wen;
    req_idx[i*64 +: 64] = c.idx;
    req_wdata[i*64 +: 64] = c.wdata;
    req_wmask[i*64 +: 64] = c.wmask;
  endtask

  // One cycle of stimulus, run 2 time units after the posedge: requesters
  // retire granted commands and present new ones, then the model predicts
  // this cycle's grant and, on a grant, queues the expected response.
  task automatic applyStimulus(input bit rnd, input int pct);
    int   g;
    bit   dropped;
    exp_t e;
    int   a;
    for (int i = 0; i < N; i++) begin
      dropped = 1'b0;
      if (req_valid[i] && prevReady[i]) begin
        req_valid[i] = 1'b0;
      end else if (req_valid[i] && rnd && ($urandom_range(9) == 0)) begin
        req_valid[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!req_valid[i] && !dropped) begin
        if (i == 0 && cmdQ0.size() != 0) presentCmd(i, cmdQ0.pop_front());
        else if (i == 1 && cmdQ1.size() != 0) presentCmd(i, cmdQ1.pop_front());
        else if (rnd && $urandom_range(2) != 0) presentCmd(i, randomCmd());
      end
      resp_ready[i] = ($urandom_range(99) < pct);
    end
    #1;
    g = (expQ.size() != 0) ? -1 : modelPick(req_valid, rrPtr);
    checkOutput("req_ready", 64'(req_ready), (g >= 0) ? 64'(onehot(g)) : 64'd0);
    if (g >= 0) begin
      a = int'(cur[g].idx[4:0]);
      e.owner   = g;
      e.idx     = cur[g].idx;
      e.rdata   = refMem[a];
      e.isWrite = cur[g].wen;
      e.due     = cycle + 2 + WAIT;
      if (cur[g].wen) refMem[a] = (refMem[a] & ~cur[g].wmask) | (cur[g].wdata & cur[g].wmask);
      expQ.push_back(e);
      rrPtr = (g + 1) % N;
    end
    prevReady = req_ready;
  endtask

  task automatic stepOnce(input bit rnd, input int pct);
    @(posedge clk);
    #2;
    applyStimulus(rnd, pct);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || cmdQ0.size() != 0 || cmdQ1.size() != 0 || req_valid != '0) && n < budget) begin
      stepOnce(1'b0, 100);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL drain timeout: used %0d cycles, required fewer than %0d", n, budget);
    end
  endtask

  // Asserts reset, discards model state (undoing an uncommitted write),
  // checks every output is zero, and releases reset after holdCycles edges.
  task automatic doReset(input bit validDuringReset, input int holdCycles);
    reset = 1'b1;
    resp_ready = '0;
    req_valid = validDuringReset ? '1 : '0;
    #1;
    if (expQ.size() != 0 && expQ[0].isWrite) refMem[int'(expQ[0].idx[4:0])] = expQ[0].rdata;
    expQ.delete();
    rrPtr = 0;
    prevReady = '0;
    checkOutput("reset req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset ram_en", 64'(ram_en), 64'd0);
    checkOutput("reset ram_wen", 64'(ram_wen), 64'd0);
    checkOutput("reset ram_rIdx", ram_rIdx, 64'd0);
    checkOutput("reset ram_wIdx", ram_wIdx, 64'd0);
    checkOutput("reset ram_wdata", ram_wdata, 64'd0);
    checkOutput("reset ram_wmask", ram_wmask, 64'd0);
    checkOutput("reset resp_rdata", resp_rdata, 64'd0);
    repeat (holdCycles) @(posedge clk);
    #2;
    req_valid = '0;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: ram port activity must match the outstanding
  // access's window, and the response must appear exactly at its due cycle
  // with the expected owner and data, held until the owner takes it.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   inAccess;
    if (!reset) begin
      if (expQ.size() != 0) begin
        e = expQ[0];
        inAccess = (cycle >= e.due - 1 - WAIT) && (cycle <= e.due - 1);
        checkOutput("ram_en", 64'(ram_en), 64'(inAccess));
        checkOutput("ram_wen", 64'(ram_wen), 64'(inAccess && e.isWrite && cycle == e.due - 1));
        if (inAccess) checkOutput("ram_rIdx", ram_rIdx, e.idx);
        if (cycle >= e.due) begin
          checkOutput("resp_valid", 64'(resp_valid), 64'(onehot(e.owner)));
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          if (resp_ready[e.owner]) void'(expQ.pop_front());
        end else begin
          checkOutput("resp_valid early", 64'(resp_valid), 64'd0);
        end
      end else begin
        checkOutput("resp_valid idle", 64'(resp_valid), 64'd0);
        checkOutput("ram_en idle", 64'(ram_en), 64'd0);
        checkOutput("ram_wen idle", 64'(ram_wen), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    cmd_t c;
    logic [63:0] v;
    req_valid  = '0;
    req_wen    = '0;
    req_idx    = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = '0;
    prevReady  = '0;
    rrPtr      = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = {$urandom, $urandom};
      if (i == 16) v = 64'h0000_0000_DEAD_BEEF;
      if (i == 5)  v = '1;
      stubMem[i] <= v;
      refMem[i] = v;
    end
    $display("[TB] reset with all requesters valid");
    doReset(1'b1, 2);

    $display("[TB] single read of idx 0x10");
    c = '{wen: 1'b0, idx: 64'h10, wdata: '0, wmask: '0};
    cmdQ0.push_back(c);
    drain(50);

    $display("[TB] masked write then read back of idx 5");
    c = '{wen: 1'b1, idx: 64'd5, wdata: 64'h1111_2222_3333_4444, wmask: 64'h0000_0000_FFFF_FFFF};
    cmdQ0.push_back(c);
    c = '{wen: 1'b0, idx: 64'd5, wdata: '0, wmask: '0};
    cmdQ0.push_back(c);
    drain(50);

    $display("[TB] both requesters saturated");
    for (int k = 0; k < 4; k++) begin
      cmdQ0.push_back(randomCmd());
      cmdQ1.push_back(randomCmd());
    end
    drain(200);

    $display("[TB] response held back from requester 1");
    c = '{wen: 1'b0, idx: 64'd9, wdata: '0, wmask: '0};
    cmdQ1.push_back(c);
    stepOnce(1'b0, 0);
    c = '{wen: 1'b0, idx: 64'd10, wdata: '0, wmask: '0};
    cmdQ0.push_back(c);
    repeat (11) stepOnce(1'b0, 0);
    drain(50);

    $display("[TB] reset during a stalled write");
    c = '{wen: 1'b1, idx: 64'd7, wdata: 64'hA5A5_5A5A_0F0F_F0F0, wmask: '1};
    cmdQ0.push_back(c);
    stepOnce(1'b0, 100);
    stepOnce(1'b0, 100);
    @(posedge clk);
    #2;
    doReset(1'b0, 4);
    checkOutput("mem word after reset", stubMem[7], refMem[7]);
    c = '{wen: 1'b0, idx: 64'd7, wdata: '0, wmask: '0};
    cmdQ1.push_back(c);
    drain(50);

    $display("[TB] randomized traffic");
    repeat (400) stepOnce(1'b1, 70);
    drain(200);

    for (int i = 0; i < MEM_WORDS; i++) begin
      checkOutput("final memory", stubMem[i], refMem[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
